// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Jump/branch targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle with a stall-type handshake.
interface fetch_stage_if;
    logic        oImemRead;
    logic [29:0] oImemAddr;
    logic [31:0] iImemRdata;
    logic        iImemStall;

    modport master (output oImemRead, oImemAddr, input iImemRdata, iImemStall);
    modport slave  (input oImemRead, oImemAddr, output iImemRdata, iImemStall);
endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic [31:0] pcplus4,
    output logic [31:0] instr_reg,
    output logic [31:0] pcplus4_reg,
    output logic        valid_reg
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg   <= NOP_INSTR;
            pcplus4_reg <= 32'h0;
            valid_reg   <= 1'b0;
        end else if (flush || (!hold && !load)) begin
            instr_reg   <= NOP_INSTR;
            pcplus4_reg <= 32'h0;
            valid_reg   <= 1'b0;
        end else if (!hold) begin
            instr_reg   <= instr;
            pcplus4_reg <= pcplus4;
            valid_reg   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, one-entry skid and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iPCEnable,
    input  logic                 iFlushIfDec,
    input  logic                 iRedirect_RegE,
    input  logic [31:0]          iTarget_RegE,
    input  logic                 iJump,
    input  logic [31:0]          iJumpTarget,
    fetch_stage_if.master        imem,
    output logic [31:0]          oInstr_RegD,
    output logic [31:0]          oPCplus4_RegD,
    output logic                 oValid_RegD,
    output logic [31:0]          oPC
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  skid_instr_reg, skid_instr_next;
    logic [31:0]  skid_pcplus4_reg, skid_pcplus4_next;
    logic [31:0]  pend_reg, pend_next;

    logic        redirect, hold, imem_read, accept;
    logic [31:0] target, pc_plus4;
    logic        load;
    logic [31:0] load_instr, load_pcplus4;

    assign redirect  = iRedirect_RegE | iJump;
    assign target    = word_align(iRedirect_RegE ? iTarget_RegE : iJumpTarget);
    assign hold      = ~iPCEnable;
    assign imem_read = (state_reg == FETCH) || (state_reg == DISCARD);
    assign accept    = imem_read & ~imem.iImemStall;
    assign pc_plus4  = pc_reg + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BOOT;
            pc_reg           <= RESET_PC;
            skid_instr_reg   <= NOP_INSTR;
            skid_pcplus4_reg <= 32'h0;
            pend_reg         <= 32'h0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            skid_instr_reg   <= skid_instr_next;
            skid_pcplus4_reg <= skid_pcplus4_next;
            pend_reg         <= pend_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        skid_instr_next   = skid_instr_reg;
        skid_pcplus4_next = skid_pcplus4_reg;
        pend_next         = pend_reg;
        load              = 1'b0;
        load_instr        = imem.iImemRdata;
        load_pcplus4      = pc_plus4;

        case (state_reg)
            BOOT: state_next = FETCH;
            FETCH: begin
                if (accept) begin
                    if (redirect) begin
                        pc_next = target;
                    end else if (hold) begin
                        // Decode is stalled: park the response so it is not lost.
                        skid_instr_next   = imem.iImemRdata;
                        skid_pcplus4_next = pc_plus4;
                        pc_next           = pc_plus4;
                        state_next        = HOLD;
                    end else begin
                        load    = 1'b1;
                        pc_next = pc_plus4;
                    end
                end else if (redirect) begin
                    pend_next  = target;
                    state_next = DISCARD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (!hold) begin
                    load         = 1'b1;
                    load_instr   = skid_instr_reg;
                    load_pcplus4 = skid_pcplus4_reg;
                    state_next   = FETCH;
                end
            end
            DISCARD: begin
                // The stalled request must complete at its old address; its data is dropped.
                if (redirect) pend_next = target;
                if (accept) begin
                    pc_next    = redirect ? target : pend_reg;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    assign imem.oImemRead = imem_read;
    assign imem.oImemAddr = pc_reg[31:2];
    assign oPC            = pc_reg;

    if_id_reg u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .hold        (hold),
        .flush       (iFlushIfDec),
        .instr       (load_instr),
        .pcplus4     (load_pcplus4),
        .instr_reg   (oInstr_RegD),
        .pcplus4_reg (oPCplus4_RegD),
        .valid_reg   (oValid_RegD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against an in-order instruction-stream model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_enable = 1'b1;
    logic        flush = 1'b0;
    logic        redir_e = 1'b0;
    logic [31:0] target_e = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] instr_d, pcplus4_d, pc;
    logic        valid_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        return t;
    endfunction

    fetch_stage_if imem();
    assign imem.iImemRdata = imem.oImemRead ? mem_word(imem.oImemAddr) : 32'hDEAD_BEEF;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iPCEnable      (pc_enable),
        .iFlushIfDec    (flush),
        .iRedirect_RegE (redir_e),
        .iTarget_RegE   (target_e),
        .iJump          (jump),
        .iJumpTarget    (jump_target),
        .imem           (imem),
        .oInstr_RegD    (instr_d),
        .oPCplus4_RegD  (pcplus4_d),
        .oValid_RegD    (valid_d),
        .oPC            (pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [29:0] waddr);
        chk({tag, "_valid"}, valid_d, 1);
        chk({tag, "_instr"}, instr_d, mem_word(waddr));
        chk({tag, "_pc4"}, pcplus4_d, {waddr, 2'b00} + 32'd4);
    endtask

    logic [29:0] exp_addr;
    logic [31:0] tgt;
    logic        p_read;
    logic [29:0] p_addr;
    logic [31:0] p_instr, p_pc4;
    logic        p_valid;
    int          delivered;

    initial begin
        imem.iImemStall = 1'b0;

        // Reset state
        step();
        chk("rst_read", imem.oImemRead, 0);
        chk("rst_valid", valid_d, 0);
        chk("rst_instr", instr_d, NOP_INSTR);
        chk("rst_pc4", pcplus4_d, 0);
        chk("rst_pc", pc, 32'h0);
        rst_n = 1'b1;
        chk("boot_read", imem.oImemRead, 0);

        // Zero-wait streaming
        step();
        chk("zw_read", imem.oImemRead, 1);
        chk("zw_addr0", imem.oImemAddr, 0);
        chk("zw_valid0", valid_d, 0);
        step(); chk("zw_addr1", imem.oImemAddr, 1); chk_ifid("zw_i0", 30'd0);
        step(); chk("zw_addr2", imem.oImemAddr, 2); chk_ifid("zw_i1", 30'd1);
        step(); chk("zw_addr3", imem.oImemAddr, 3); chk_ifid("zw_i2", 30'd2);
        step(); chk("zw_addr4", imem.oImemAddr, 4); chk_ifid("zw_i3", 30'd3);

        // Memory stall at PC 0x10 for 3 cycles
        imem.iImemStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_read", imem.oImemRead, 1);
            chk("st_addr", imem.oImemAddr, 4);
            chk("st_valid", valid_d, 0);
        end
        imem.iImemStall = 1'b0;
        step(); chk("st_addr5", imem.oImemAddr, 5); chk_ifid("st_i4", 30'd4);

        // Load-use hold while a response is accepted
        pc_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hd_read", imem.oImemRead, 0);
            chk_ifid("hd_keep", 30'd4);
        end
        pc_enable = 1'b1;
        step(); chk("hd_addr6", imem.oImemAddr, 6); chk("hd_read1", imem.oImemRead, 1); chk_ifid("hd_i5", 30'd5);
        step(); chk("hd_addr7", imem.oImemAddr, 7); chk_ifid("hd_i6", 30'd6);

        // EX redirect during a memory stall
        imem.iImemStall = 1'b1; redir_e = 1'b1; target_e = 32'h100;
        step(); chk("dc_addr", imem.oImemAddr, 7); chk("dc_read", imem.oImemRead, 1); chk("dc_valid", valid_d, 0);
        redir_e = 1'b0;
        step(); chk("dc_addr_hold", imem.oImemAddr, 7);
        imem.iImemStall = 1'b0;
        step(); chk("dc_addr_tgt", imem.oImemAddr, 30'h40); chk("dc_drop", valid_d, 0);
        step(); chk("dc_addr_nxt", imem.oImemAddr, 30'h41); chk_ifid("dc_i40", 30'h40);

        // Jump and EX redirect together, with flush
        jump = 1'b1; jump_target = 32'h200; redir_e = 1'b1; target_e = 32'h300; flush = 1'b1;
        step(); chk("jx_addr", imem.oImemAddr, 30'hC0); chk("jx_valid", valid_d, 0);
        jump = 1'b0; redir_e = 1'b0; flush = 1'b0;
        step(); chk_ifid("jx_iC0", 30'hC0);

        // Unaligned target has its low bits cleared
        jump = 1'b1; jump_target = 32'h403; flush = 1'b1;
        step(); chk("al_pc", pc, 32'h400);
        jump = 1'b0; flush = 1'b0;

        // Asynchronous reset in the middle of DISCARD
        imem.iImemStall = 1'b1; redir_e = 1'b1; target_e = 32'h500;
        step(); redir_e = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_read", imem.oImemRead, 0);
        chk("ar_pc", pc, 32'h0);
        chk("ar_valid", valid_d, 0);
        chk("ar_instr", instr_d, NOP_INSTR);
        step();
        rst_n = 1'b1; imem.iImemStall = 1'b0;
        chk("ar_boot_read", imem.oImemRead, 0);
        step();
        chk("ar_first_read", imem.oImemRead, 1);
        chk("ar_first_addr", imem.oImemAddr, 0);

        // Randomized phase: in-order, lossless, duplicate-free stream plus handshake rules
        exp_addr = 30'd0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int ev;
            imem.iImemStall = ($urandom_range(0, 9) < 3);
            pc_enable       = ($urandom_range(0, 9) >= 3);
            ev              = int'($urandom_range(0, 19));
            redir_e         = (ev == 0) || (ev == 2);
            jump            = (ev == 1) || (ev == 2);
            target_e        = rand_target();
            jump_target     = rand_target();
            flush           = redir_e | jump;
            p_read  = imem.oImemRead;
            p_addr  = imem.oImemAddr;
            p_instr = instr_d;
            p_pc4   = pcplus4_d;
            p_valid = valid_d;
            step();
            if (p_read && imem.iImemStall) begin
                chk("rnd_hs_read", imem.oImemRead, 1);
                chk("rnd_hs_addr", imem.oImemAddr, p_addr);
            end
            if (redir_e || jump) begin
                tgt = redir_e ? target_e : jump_target;
                exp_addr = tgt[31:2];
                chk("rnd_flush", valid_d, 0);
                if (!(p_read && imem.iImemStall)) begin
                    chk("rnd_rd_read", imem.oImemRead, 1);
                    chk("rnd_rd_addr", imem.oImemAddr, tgt[31:2]);
                end
            end else if (!pc_enable) begin
                chk("rnd_keep_valid", valid_d, p_valid);
                chk("rnd_keep_instr", instr_d, p_instr);
                chk("rnd_keep_pc4", pcplus4_d, p_pc4);
            end else if (valid_d) begin
                chk("rnd_instr", instr_d, mem_word(exp_addr));
                chk("rnd_pc4", pcplus4_d, {exp_addr, 2'b00} + 32'd4);
                exp_addr = exp_addr + 30'd1;
                delivered++;
            end
        end
        chk("rnd_progress", (delivered > 500) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage and driven by the hazard detection unit. It owns the PC, issues word reads to instruction memory over a stall-type handshake, and loads the IF/ID pipeline register. The IF/ID register is held by `iPCEnable` (load-use stall), bubbled by `iFlushIfDec`, and redirected by EX-resolved JR/taken branches or decode-resolved J/JAL. A one-entry skid buffer absorbs a memory response that lands while decode is held.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `iPCEnable` in 1: from hazard unit; 0 = hold PC and IF/ID (load-use stall).
- `iFlushIfDec` in 1: from hazard unit; 1 = write a bubble into IF/ID this edge.
- `iRedirect_RegE` in 1: JR or taken branch resolved in EX.
- `iTarget_RegE` in 32: EX redirect target.
- `iJump` in 1: J/JAL in decode.
- `iJumpTarget` in 32: decode jump target.
- `oImemRead` in/out: out 1, read request.
- `oImemAddr` out 30: word address, PC[31:2].
- `iImemRdata` in 32: instruction, valid when `oImemRead`=1 and `iImemStall`=0.
- `iImemStall` in 1: memory busy; request not accepted this cycle.
- `oInstr_RegD` out 32: IF/ID instruction.
- `oPCplus4_RegD` out 32: IF/ID PC+4.
- `oValid_RegD` out 1: IF/ID holds a real instruction.
- `oPC` out 32: current fetch PC.

## Operation
- Reset values: PC=`RESET_PC`, state BOOT, `oImemRead`=0, `oInstr_RegD`=0 (NOP), `oPCplus4_RegD`=0, `oValid_RegD`=0, skid empty.
- redirect = `iRedirect_RegE` | `iJump`; target = `iRedirect_RegE` ? `iTarget_RegE` : `iJumpTarget` (EX wins). Target bits [1:0] are forced to 0.
- accept = `oImemRead` & ~`iImemStall`; hold = ~`iPCEnable`.
- BOOT: `oImemRead`=0, IF/ID bubble; next state FETCH.
- FETCH: `oImemRead`=1, `oImemAddr`=PC[31:2].
  - accept & redirect: drop data, PC<=target, stay in FETCH.
  - accept & hold: skid<=data and PC+4, PC<=PC+4, go to HOLD.
  - accept otherwise: IF/ID<={data, PC+4, valid=1}, PC<=PC+4.
  - ~accept & redirect: pend<=target, go to DISCARD.
  - ~accept & ~hold: IF/ID bubble.
- HOLD: `oImemRead`=0.
  - redirect: drop skid, PC<=target, go to FETCH.
  - ~hold: IF/ID<=skid, go to FETCH.
- DISCARD: `oImemRead`=1 with the old address held stable.
  - On accept: drop data, PC<=pend, go to FETCH.
  - A later redirect overwrites pend, EX target still first.
- IF/ID priority, highest first:
  - reset;
  - `iFlushIfDec`: bubble, overriding hold;
  - hold: keep contents;
  - load per state;
  - otherwise bubble.
- Redirect overrides hold: a load-use stall never blocks a redirect.
- PC+4 wraps modulo 2^32.
- The skid and IF/ID never both drop a valid sequential instruction. No instruction is duplicated.

## Timing
- Zero-wait memory: the instruction at PC requested in cycle n appears on `oInstr_RegD` in cycle n+1. Throughput is one per cycle.
- Handshake: once `oImemRead` rises, `oImemAddr` stays stable until accept. `oImemRead` never drops before accept.
- Redirect in cycle n, memory not stalled: `oImemAddr`=target[31:2] in n+1.
- Redirect during a stall: target is issued the cycle after the stalled request is accepted.
- HOLD adds no bubble: the skid enters IF/ID on the first edge with `iPCEnable`=1.
- `rst_n` low at any time, including mid-stall or DISCARD: outputs take reset values immediately. The first request comes 2 cycles after deassertion.

## Structure
- Shared package holds:
  - state enum {BOOT, FETCH, HOLD, DISCARD};
  - `NOP_INSTR`=32'h0;
  - `RESET_PC` default.
- Sub-module `if_id_reg` holds instr, PC+4 and valid, with load, hold and flush controls. The FSM, PC, skid and pend registers stay in `fetch_stage`.

## Test plan
- Reset release, zero-wait memory → `oImemAddr` = 0, 1, 2 on consecutive cycles from cycle 2; `oPCplus4_RegD` = 4, 8, 12.
- `iImemStall`=1 for 3 cycles at PC 0x10 → `oImemAddr`=4 held, `oValid_RegD`=0 for 3 cycles; the instruction appears the cycle after the stall drops.
- `iPCEnable`=0 for 2 cycles while a response is accepted → IF/ID unchanged, skid captures; after enable, instructions continue in order with none lost or duplicated.
- `iRedirect_RegE`=1, target 0x100, during `iImemStall`=1 → DISCARD; stalled data dropped; next request `oImemAddr`=0x40.
- `iJump` (target 0x200) and `iRedirect_RegE` (target 0x300) in the same cycle with `iFlushIfDec`=1 → IF/ID bubble, next `oImemAddr`=0xC0.
- `rst_n` pulsed low mid-DISCARD → `oImemRead`=0, PC=`RESET_PC`, `oValid_RegD`=0 without waiting for a clock edge.
